// File: rtl/conv_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : conv_engine                                                     |
// | Purpose  : Pipelined FIR convolution: delay line, registered products,     |
// |            binary adder tree, rounding shift. Define CONV_SAT_EN to clamp  |
// |            the output and drive a sticky sat_flag (default: wrap).         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module conv_engine #(
    parameter int DATA_SIZE   = 16,
    parameter int WINDOW_SIZE = 20,
    parameter int EXTRA_BITS  = 5,
    parameter int OUT_SIZE    = 16,
    parameter int OUT_SHIFT   = 15
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           coef_wr_en,
    input  logic [$clog2(WINDOW_SIZE)-1:0] coef_addr,
    input  logic [DATA_SIZE-1:0]           coef_data,
    input  logic                           clear,
    input  logic                           in_valid,
    input  logic [DATA_SIZE-1:0]           in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic [OUT_SIZE-1:0]            out_data,
    output logic                           sat_flag
);

    localparam int ADDER_STAGES = $clog2(WINDOW_SIZE);
    localparam int FULL_SIZE    = 2*DATA_SIZE + EXTRA_BITS;
    localparam int c_PROD_W     = 2*DATA_SIZE;
    localparam int c_DRAIN_CYC  = ADDER_STAGES + 2;
    localparam int c_CNT_W      = $clog2(c_DRAIN_CYC + 1);

    localparam logic c_RUN   = 1'b0;
    localparam logic c_DRAIN = 1'b1;

    if (EXTRA_BITS < ADDER_STAGES) begin : g_bad_extra_bits
        $error("conv_engine: EXTRA_BITS must be at least clog2(WINDOW_SIZE)");
    end

    function automatic int node_count(input int level);
        int n;
        n = WINDOW_SIZE;
        for (int i = 0; i < level; i++) n = (n + 1) / 2;
        return n;
    endfunction

    logic                r_state;
    logic                w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                w_accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (clear)
                r_cnt <= c_CNT_W'(c_DRAIN_CYC - 1);
            else if (r_state == c_DRAIN && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_RUN:   if (clear) w_state_nxt = c_DRAIN;
            c_DRAIN: if (!clear && r_cnt == '0) w_state_nxt = c_RUN;
            default: w_state_nxt = c_RUN;
        endcase
    end

    always_comb begin
        in_ready = (r_state == c_RUN);
    end

    assign w_accept = in_valid & in_ready & ~clear;

    logic signed [DATA_SIZE-1:0]    r_tap  [WINDOW_SIZE];
    logic signed [DATA_SIZE-1:0]    r_coef [WINDOW_SIZE];
    logic                           r_pend_en;
    logic [ADDER_STAGES-1:0]        r_pend_addr;
    logic signed [DATA_SIZE-1:0]    r_pend_data;

    // Coefficient writes land in r_coef one edge late: the product stage reads
    // r_coef one edge after acceptance, so a sample accepted together with a
    // write still multiplies by the old coefficient.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < WINDOW_SIZE; k++) begin
                r_tap[k]  <= '0;
                r_coef[k] <= '0;
            end
            r_pend_en   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else begin
            if (clear) begin
                for (int k = 0; k < WINDOW_SIZE; k++) r_tap[k] <= '0;
            end else if (w_accept) begin
                r_tap[0] <= in_data;
                for (int k = 1; k < WINDOW_SIZE; k++) r_tap[k] <= r_tap[k-1];
            end
            r_pend_en   <= coef_wr_en && (int'(coef_addr) < WINDOW_SIZE);
            r_pend_addr <= coef_addr;
            r_pend_data <= coef_data;
            if (r_pend_en) r_coef[r_pend_addr] <= r_pend_data;
        end
    end

    logic signed [c_PROD_W-1:0]  w_prod [WINDOW_SIZE];
    logic signed [FULL_SIZE-1:0] r_tree [ADDER_STAGES+1][WINDOW_SIZE];
    logic [ADDER_STAGES+1:0]     r_vld;

    always_comb begin
        for (int k = 0; k < WINDOW_SIZE; k++) w_prod[k] = r_tap[k] * r_coef[k];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < WINDOW_SIZE; k++) r_tree[0][k] <= '0;
            r_vld <= '0;
        end else begin
            for (int k = 0; k < WINDOW_SIZE; k++) r_tree[0][k] <= FULL_SIZE'(w_prod[k]);
            r_vld <= {r_vld[ADDER_STAGES:0], w_accept};
        end
    end

    for (genvar l = 1; l <= ADDER_STAGES; l++) begin : g_level
        localparam int c_N_IN  = node_count(l - 1);
        localparam int c_N_OUT = node_count(l);
        for (genvar j = 0; j < c_N_OUT; j++) begin : g_node
            if (2*j + 1 < c_N_IN) begin : g_add
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) r_tree[l][j] <= '0;
                    else          r_tree[l][j] <= r_tree[l-1][2*j] + r_tree[l-1][2*j+1];
                end
            end else begin : g_pass
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) r_tree[l][j] <= '0;
                    else          r_tree[l][j] <= r_tree[l-1][2*j];
                end
            end
        end
    end

    logic signed [FULL_SIZE-1:0] w_sum;
    logic signed [FULL_SIZE-1:0] w_shifted;
    logic [OUT_SIZE-1:0]         w_out;

    assign w_sum = r_tree[ADDER_STAGES][0];

    if (OUT_SHIFT > 0) begin : g_round
        localparam logic signed [FULL_SIZE-1:0] c_ROUND = FULL_SIZE'(1) <<< (OUT_SHIFT - 1);
        assign w_shifted = (w_sum + c_ROUND) >>> OUT_SHIFT;
    end else begin : g_no_round
        assign w_shifted = w_sum;
    end

`ifdef CONV_SAT_EN
    logic w_hi_ones;
    logic w_hi_zeros;
    logic w_ovf;
    logic r_sat;

    assign w_hi_ones  = &w_shifted[FULL_SIZE-1:OUT_SIZE-1];
    assign w_hi_zeros = ~|w_shifted[FULL_SIZE-1:OUT_SIZE-1];
    assign w_ovf      = ~(w_hi_ones | w_hi_zeros);

    always_comb begin
        w_out = w_shifted[OUT_SIZE-1:0];
        if (w_ovf)
            w_out = w_shifted[FULL_SIZE-1] ? {1'b1, {(OUT_SIZE-1){1'b0}}}
                                           : {1'b0, {(OUT_SIZE-1){1'b1}}};
    end

    // A saturating result on the same edge as clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          r_sat <= 1'b0;
        else if (r_vld[ADDER_STAGES+1] && w_ovf) r_sat <= 1'b1;
        else if (clear)                        r_sat <= 1'b0;
    end

    assign sat_flag = r_sat;
`else
    logic w_unused_hi;

    assign w_out       = w_shifted[OUT_SIZE-1:0];
    assign w_unused_hi = ^w_shifted[FULL_SIZE-1:OUT_SIZE];
    assign sat_flag    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= r_vld[ADDER_STAGES+1];
            if (r_vld[ADDER_STAGES+1]) out_data <= w_out;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_engine.sv
`default_nettype none
// Scoreboard bench for conv_engine: a behavioural FIR model queues the expected
// result and output cycle of each accepted sample; a negedge monitor retires them.
module tb_conv_engine;

    localparam int W = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        coef_wr_en = 1'b0;
    logic [4:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        sat_flag;

    always #5 clk = ~clk;

    conv_engine dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .coef_wr_en (coef_wr_en),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .sat_flag   (sat_flag)
    );

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t               exp_q[$];
    exp_t               mon_e;
    logic signed [15:0] m_tap  [W];
    logic signed [15:0] m_coef [W];
    logic               m_sat = 1'b0;
    int                 cyc = 0;
    int                 n_err = 0;
    int                 n_chk = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_out();
        longint s;
        s = 0;
        for (int k = 0; k < W; k++) s += longint'(m_tap[k]) * longint'(m_coef[k]);
        s = (s + 64'sd16384) >>> 15;
`ifdef CONV_SAT_EN
        if (s > 32767)  begin m_sat = 1'b1; return 16'h7fff; end
        if (s < -32768) begin m_sat = 1'b1; return 16'h8000; end
`endif
        return s[15:0];
    endfunction

    task automatic step(input logic v, input logic [15:0] d, input logic we,
                        input logic [4:0] a, input logic [15:0] cd, input logic clr);
        exp_t x;
        in_valid = v; in_data = d; coef_wr_en = we; coef_addr = a; coef_data = cd; clear = clr;
        if (v && !clr) begin
            check("in_ready_when_driving", in_ready, 1);
            for (int k = W-1; k > 0; k--) m_tap[k] = m_tap[k-1];
            m_tap[0] = d;
            x.data = model_out();
            x.cyc  = cyc + 8;
            exp_q.push_back(x);
        end
        if (clr) for (int k = 0; k < W; k++) m_tap[k] = '0;
        if (we && a < W) m_coef[a] = cd;
        @(posedge clk); #1;
        in_valid = 1'b0; coef_wr_en = 1'b0; clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 16'h0, 0, 5'd0, 16'h0, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin idle(1); n++; end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    endtask

    // mode 0: k+1, mode 1: 0x7fff, mode 2: zero
    task automatic set_coefs(input int mode);
        for (int k = 0; k < W; k++)
            step(0, 16'h0, 1, 5'(k), (mode == 0) ? 16'(k+1) : (mode == 1) ? 16'h7fff : 16'h0, 0);
    endtask

    task automatic impulse();
        step(1, 16'h7fff, 0, 5'd0, 16'h0, 0);
        repeat (W-1) step(1, 16'h0, 0, 5'd0, 16'h0, 0);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", out_data, mon_e.data);
                check("out_latency_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;
        for (int k = 0; k < W; k++) begin m_tap[k] = '0; m_coef[k] = '0; end

        repeat (2) @(posedge clk); #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_sat_flag", sat_flag, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Impulse through ramp coefficients yields 1..20; address 25 must be ignored.
        set_coefs(0);
        step(0, 16'h0, 1, 5'd25, 16'h1234, 0);
        impulse();
        drain();

        // Gapped, random input against random small coefficients.
        for (int k = 0; k < W; k++) begin
            c = int'($urandom_range(0, 4095)) - 2048;
            step(0, 16'h0, 1, 5'(k), 16'(c), 0);
        end
        for (int i = 0; i < 40; i++)
            step(((i % 3) != 1) ? 1'b1 : 1'($urandom_range(0, 1)), 16'($urandom), 0, 5'd0, 16'h0, 0);
        drain();

        // Coefficient write on the accepting edge: that sample sees the old value.
        set_coefs(2);
        step(0, 16'h0, 1, 5'd0, 16'h0001, 0);
        step(1, 16'h4000, 1, 5'd0, 16'h0002, 0);
        step(1, 16'h4000, 1, 5'd0, 16'h2000, 0);
        step(1, 16'h4000, 1, 5'd0, 16'h6000, 0);
        step(1, 16'h4000, 0, 5'd0, 16'h0, 0);
        drain();

        // Clear after 10 samples: sample on the clear edge dropped, 7-cycle drain.
        set_coefs(0);
        repeat (10) step(1, 16'($urandom_range(0, 16'h3fff)), 0, 5'd0, 16'h0, 0);
        step(1, 16'h1111, 0, 5'd0, 16'h0, 1);
        wait_ready(n);
        check("clear_in_ready_low_cycles", n, 7);
        impulse();
        drain();

        // Saturation (clamp with CONV_SAT_EN, wrap otherwise).
        set_coefs(1);
        repeat (W) step(1, 16'h7fff, 0, 5'd0, 16'h0, 0);
        drain();
        check("sat_flag_after_pos", sat_flag, m_sat);
        repeat (W) step(1, 16'h8000, 0, 5'd0, 16'h0, 0);
        drain();
        check("sat_flag_after_neg", sat_flag, m_sat);
        step(0, 16'h0, 0, 5'd0, 16'h0, 1);
        m_sat = 1'b0;
        check("sat_flag_after_clear", sat_flag, 0);
        wait_ready(n);
        check("sat_clear_in_ready_low_cycles", n, 7);

        // Asynchronous reset with results in flight.
        set_coefs(0);
        repeat (12) step(1, 16'($urandom_range(1, 16'h3fff)), 0, 5'd0, 16'h0, 0);
        reset_n = 1'b0;
        #1;
        check("reset_mid_out_valid", out_valid, 0);
        check("reset_mid_in_ready", in_ready, 1);
        exp_q.delete();
        for (int k = 0; k < W; k++) begin m_tap[k] = '0; m_coef[k] = '0; end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        idle(10);
        impulse();
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16, input sample and coefficient width (signed two's complement).
REQ-002 SHALL have parameter WINDOW_SIZE, default 20, number of taps.
REQ-003 SHALL have parameter EXTRA_BITS, default 5, accumulator guard bits; elaboration SHALL fail if EXTRA_BITS < clog2(WINDOW_SIZE).
REQ-004 SHALL have parameter OUT_SIZE, default 16, output width.
REQ-005 SHALL have parameter OUT_SHIFT, default 15, arithmetic right shift applied to the accumulator before output.
REQ-006 SHALL derive ADDER_STAGES = clog2(WINDOW_SIZE) and FULL_SIZE = 2*DATA_SIZE + EXTRA_BITS as localparams.
REQ-007 clk  in  1  single clock, all state on rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 coef_wr_en  in  1  coefficient write strobe.
REQ-010 coef_addr  in  clog2(WINDOW_SIZE)  tap index to write.
REQ-011 coef_data  in  DATA_SIZE  signed coefficient value.
REQ-012 clear  in  1  one-cycle pulse: zero delay line and drain pipeline.
REQ-013 in_valid  in  1  input sample qualifier.
REQ-014 in_data  in  DATA_SIZE  signed input sample.
REQ-015 in_ready  out  1  block accepts a sample when in_valid and in_ready both high.
REQ-016 out_valid  out  1  one-cycle result qualifier, no backpressure.
REQ-017 out_data  out  OUT_SIZE  signed filtered result.
REQ-018 sat_flag  out  1  sticky saturation indicator.

Function
REQ-019 On acceptance, delay line SHALL shift: tap0 <= in_data, tap[k] <= tap[k-1]; no shift without acceptance.
REQ-020 Stage 1 SHALL register WINDOW_SIZE products tap[k]*coef[k], each 2*DATA_SIZE bits signed.
REQ-021 Products SHALL be summed in a binary adder tree of ADDER_STAGES registered levels, sign-extended to FULL_SIZE, odd operand passed through; no overflow possible at FULL_SIZE.
REQ-022 Output stage SHALL compute (sum + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (no rounding term when OUT_SHIFT=0) and register it to out_data.
REQ-023 Latency SHALL be exactly ADDER_STAGES+2 cycles from accepting edge to out_valid high (7 at defaults); one out_valid per accepted sample, order preserved.
REQ-024 Coefficient write SHALL update coef[coef_addr] on the edge; a sample accepted on the same edge SHALL use the old value; coef_addr >= WINDOW_SIZE SHALL be ignored.
REQ-025 FSM states RUN and DRAIN: RUN->DRAIN on clear; DRAIN holds ADDER_STAGES+2 cycles via down-counter, then ->RUN.
REQ-026 in_ready SHALL be 1 in RUN, 0 in DRAIN; a clear coinciding with in_valid SHALL drop that sample.
REQ-027 On clear, all delay-line taps SHALL zero on that edge; samples already in flight SHALL still produce their outputs during DRAIN.
REQ-028 clear during DRAIN SHALL reload the counter; coefficient writes SHALL be allowed in both states.

Reset
REQ-029 reset_n low SHALL immediately zero taps, coefficients, all pipeline registers, out_data, out_valid, sat_flag, counter; state RUN.
REQ-030 in_ready SHALL be 1 during and after reset; reset mid-stream SHALL discard all in-flight results with no out_valid emitted.

Configuration
REQ-031 Macro CONV_SAT_EN defined: shifted value outside OUT_SIZE signed range SHALL clamp to max/min and set sat_flag, which stays 1 until reset_n or clear.
REQ-032 CONV_SAT_EN undefined: out_data SHALL be the low OUT_SIZE bits of the shifted value (wrap), sat_flag tied 0, no saturation logic synthesised.

Verification
REQ-033 Impulse: coef[k]=k+1, one sample 0x7FFF then 19 zeros -> out_data 1,2,...,20 in order, first at 7 cycles after acceptance.
REQ-034 Saturation (CONV_SAT_EN): all coef 0x7FFF, 20 samples 0x7FFF -> last out_data 0x7FFF, sat_flag 1; samples 0x8000 -> 0x8000; without macro -> wrapped low 16 bits, sat_flag 0.
REQ-035 Clear mid-stream: clear after 10 samples -> in_ready low 7 cycles, 10 outputs still emitted, next impulse response starts clean with no history.
REQ-036 Coef write collision: write coef[0]=2 on same edge as accepting 0x4000 with coef[0]=1 -> that output uses 1, next sample uses 2.
REQ-037 Reset mid-operation: reset_n low with 5 results in flight -> out_valid 0 immediately, no stale outputs after release, coefficients read 0 (impulse yields zeros).
REQ-038 Gapped input: in_valid toggling 1-0-1 -> outputs match the unstalled reference model sample-for-sample.
